// File: rtl/abs_pipe_if.sv
// Operand/result stream bundle for abs_pipe: operand in, result plus overflow status out.
// The master side drives operands and accepts results; the slave side is the unit itself.
interface abs_pipe_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;
   logic [CNT_W-1:0] ovf_count;

   modport master (
      output in_valid, in_data, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, ovf_count
   );

   modport slave (
      input  in_valid, in_data, in_op, out_ready,
      output in_ready, out_valid, out_data, out_ovf, ovf_count
   );
endinterface

// File: rtl/abs_pipe.sv
// abs_pipe: pipelined |x| / -x unit; result valid STAGES-1 edges after the operand is accepted.
// Backpressure: in_ready is combinational from out_ready through the stage chain; empty stages always accept.
module abs_pipe #(
   parameter int WIDTH    = 16,
   parameter int STAGES   = 2,
   parameter bit SATURATE = 1'b0,
   parameter int CNT_W    = 16
) (
   input logic       clk,
   input logic       rst,
   abs_pipe_if.slave bus
);

   typedef struct packed {
      logic             vld;
      logic             ovf;
      logic [WIDTH-1:0] dat;
   } stage_t;

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   stage_t           pipe [STAGES];
   stage_t           s1;
   logic [STAGES-1:0] adv;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic [CNT_W-1:0] cnt;

   // Abs and negate share one adder: the invert mask and carry-in are both
   // "op is negate, or operand is negative".
   always_comb begin
      cin    = bus.in_op | bus.in_data[WIDTH-1];
      sum    = (bus.in_data ^ {WIDTH{cin}}) + {{(WIDTH-1){1'b0}}, cin};
      s1.vld = bus.in_valid;
      s1.ovf = (bus.in_data == MIN_VAL);
      s1.dat = sum;
      if (s1.ovf) begin
         s1.dat = SATURATE ? MAX_VAL : bus.in_data;
      end
   end

   // A stage may load when it, or any stage downstream of it, is empty or the consumer takes a result.
   always_comb begin
      logic acc;
      acc = bus.out_ready;
      adv = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         acc    = acc | ~pipe[k].vld;
         adv[k] = acc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            pipe[k] <= '0;
         end
         cnt <= '0;
      end else begin
         if (adv[0]) begin
            pipe[0] <= s1;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
               pipe[k] <= pipe[k-1];
            end
         end
         if (pipe[STAGES-1].vld && bus.out_ready && pipe[STAGES-1].ovf && (cnt != '1)) begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = pipe[STAGES-1].vld;
   assign bus.out_data  = pipe[STAGES-1].dat;
   assign bus.out_ovf   = pipe[STAGES-1].ovf;
   assign bus.ovf_count = cnt;

endmodule

// File: tb/tb_abs_pipe.sv
// Bench for abs_pipe: three instances (wrap/saturate at depth 2, depth 3 with a 4-bit counter)
// checked against an integer-arithmetic reference model.
module tb_abs_pipe;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   exp_cnt_a = 0;

   always #5 clk = ~clk;

   abs_pipe_if #(.WIDTH(16), .CNT_W(16)) if0 ();
   abs_pipe_if #(.WIDTH(16), .CNT_W(16)) if1 ();
   abs_pipe_if #(.WIDTH(16), .CNT_W(4))  if2 ();

   // d0 and d1 see identical stimulus; they differ only in SATURATE.
   assign if1.in_valid  = if0.in_valid;
   assign if1.in_data   = if0.in_data;
   assign if1.in_op     = if0.in_op;
   assign if1.out_ready = if0.out_ready;

   abs_pipe #(.WIDTH(16), .STAGES(2), .SATURATE(1'b0), .CNT_W(16)) d0 (.clk(clk), .rst(rst), .bus(if0));
   abs_pipe #(.WIDTH(16), .STAGES(2), .SATURATE(1'b1), .CNT_W(16)) d1 (.clk(clk), .rst(rst), .bus(if1));
   abs_pipe #(.WIDTH(16), .STAGES(3), .SATURATE(1'b0), .CNT_W(4))  d2 (.clk(clk), .rst(rst), .bus(if2));

   // Returns {ovf, result} computed with plain signed integer arithmetic.
   function automatic logic [16:0] ref_res(input logic [15:0] x, input logic op, input bit sat);
      int v, r;
      v = int'($signed(x));
      r = (op || v < 0) ? -v : v;
      if (r == 32768) return {1'b1, sat ? 16'h7FFF : x};
      return {1'b0, r[15:0]};
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      if0.in_valid = 1'b0; if0.in_data = '0; if0.in_op = 1'b0; if0.out_ready = 1'b0;
      if2.in_valid = 1'b0; if2.in_data = '0; if2.in_op = 1'b0; if2.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_vld_d0 got=%b exp=0", if0.out_valid); end
      checks++; if (if0.out_data !== 16'h0) begin failures++; $display("FAIL reset_dat_d0 got=%h exp=0000", if0.out_data); end
      checks++; if (if0.out_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf_d0 got=%b exp=0", if0.out_ovf); end
      checks++; if (if0.ovf_count !== 16'h0) begin failures++; $display("FAIL reset_cnt_d0 got=%h exp=0", if0.ovf_count); end
      checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL reset_rdy_d0 got=%b exp=1", if0.in_ready); end
      checks++; if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_vld_d1 got=%b exp=0", if1.out_valid); end
      checks++; if (if2.out_valid !== 1'b0) begin failures++; $display("FAIL reset_vld_d2 got=%b exp=0", if2.out_valid); end
      checks++; if (if2.ovf_count !== 4'h0) begin failures++; $display("FAIL reset_cnt_d2 got=%h exp=0", if2.ovf_count); end
      checks++; if (if2.in_ready !== 1'b1) begin failures++; $display("FAIL reset_rdy_d2 got=%b exp=1", if2.in_ready); end
   endtask

   // Abs stream, 0x8000 both ops, negate cases: back-to-back with exact latency.
   task automatic test_directed;
      logic [15:0] xs [9];
      logic [8:0]  ops;
      logic [16:0] e0, e1;
      xs  = '{16'h0005, 16'hFFFB, 16'h0000, 16'h7FFF, 16'h8000, 16'h8000, 16'h0001, 16'hFFFF, 16'h0000};
      ops = 9'b111100000;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         if0.out_ready = 1'b1;
         if (c < 9) begin
            if0.in_valid = 1'b1; if0.in_data = xs[c]; if0.in_op = ops[c];
         end else begin
            if0.in_valid = 1'b0;
         end
         #1;
         checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL dir_rdy c=%0d got=%b exp=1", c, if0.in_ready); end
         if (c >= 2) begin
            e0 = ref_res(xs[c-2], ops[c-2], 1'b0);
            e1 = ref_res(xs[c-2], ops[c-2], 1'b1);
            if (e0[16]) exp_cnt_a++;
            checks++; if (if0.out_valid !== 1'b1) begin failures++; $display("FAIL dir_vld c=%0d got=%b exp=1", c, if0.out_valid); end
            checks++; if ({if0.out_ovf, if0.out_data} !== e0) begin failures++; $display("FAIL dir_d0 c=%0d got=%h exp=%h", c, {if0.out_ovf, if0.out_data}, e0); end
            checks++; if ({if1.out_ovf, if1.out_data} !== e1) begin failures++; $display("FAIL dir_d1 c=%0d got=%h exp=%h", c, {if1.out_ovf, if1.out_data}, e1); end
         end else begin
            checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL dir_lat c=%0d got=%b exp=0", c, if0.out_valid); end
         end
      end
      @(negedge clk);
      #1;
      checks++; if (if0.ovf_count !== 16'd2) begin failures++; $display("FAIL dir_cnt_d0 got=%0d exp=2", if0.ovf_count); end
      checks++; if (if1.ovf_count !== 16'd2) begin failures++; $display("FAIL dir_cnt_d1 got=%0d exp=2", if1.ovf_count); end
   endtask

   task automatic test_random;
      logic [15:0] qx [$];
      logic        qop [$];
      logic [15:0] x;
      logic [16:0] e0, e1, held_v;
      logic        held, exp_rdy, op;
      held = 1'b0; held_v = '0;
      for (int c = 0; c < 420; c++) begin
         @(negedge clk);
         if (c < 400) begin
            case ($urandom_range(0, 7))
               0: x = 16'h8000;
               1: x = 16'h0000;
               2: x = 16'h7FFF;
               3: x = 16'hFFFF;
               default: x = 16'($urandom);
            endcase
            if0.in_valid  = ($urandom_range(0, 3) != 0);
            if0.in_data   = x;
            if0.in_op     = 1'($urandom_range(0, 1));
            if0.out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            if0.in_valid = 1'b0; if0.out_ready = 1'b1;
         end
         #1;
         exp_rdy = !(qx.size() == 2 && !if0.out_ready);
         checks++; if (if0.in_ready !== exp_rdy) begin failures++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, if0.in_ready, exp_rdy); end
         if (held) begin
            checks++; if (!if0.out_valid || {if0.out_ovf, if0.out_data} !== held_v) begin failures++; $display("FAIL rnd_hold c=%0d got=%h exp=%h", c, {if0.out_ovf, if0.out_data}, held_v); end
         end
         if (if0.out_valid && if0.out_ready) begin
            checks++;
            if (qx.size() == 0) begin
               failures++; $display("FAIL rnd_spurious c=%0d got=%h exp=none", c, if0.out_data);
            end else begin
               x = qx.pop_front(); op = qop.pop_front();
               e0 = ref_res(x, op, 1'b0);
               e1 = ref_res(x, op, 1'b1);
               if (e0[16]) exp_cnt_a++;
               if ({if0.out_ovf, if0.out_data} !== e0) begin failures++; $display("FAIL rnd_d0 c=%0d got=%h exp=%h", c, {if0.out_ovf, if0.out_data}, e0); end
               checks++;
               if (!if1.out_valid || {if1.out_ovf, if1.out_data} !== e1) begin failures++; $display("FAIL rnd_d1 c=%0d got=%h exp=%h", c, {if1.out_ovf, if1.out_data}, e1); end
            end
         end
         held   = if0.out_valid && !if0.out_ready;
         held_v = {if0.out_ovf, if0.out_data};
         if (if0.in_valid && if0.in_ready) begin
            qx.push_back(if0.in_data); qop.push_back(if0.in_op);
         end
      end
      checks++; if (qx.size() != 0) begin failures++; $display("FAIL rnd_drain got=%0d exp=0", qx.size()); end
      checks++; if (if0.ovf_count !== exp_cnt_a[15:0]) begin failures++; $display("FAIL rnd_cnt_d0 got=%0d exp=%0d", if0.ovf_count, exp_cnt_a); end
      checks++; if (if1.ovf_count !== exp_cnt_a[15:0]) begin failures++; $display("FAIL rnd_cnt_d1 got=%0d exp=%0d", if1.ovf_count, exp_cnt_a); end
   endtask

   task automatic test_backpressure;
      logic [15:0] expq [$];
      logic [16:0] e;
      int n_acc;
      n_acc = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if2.out_ready = 1'b0; if2.in_valid = 1'b1; if2.in_op = 1'b0;
         if2.in_data = 16'hFF00 + 16'(n_acc);
         #1;
         if (c >= 3) begin
            checks++; if (if2.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_rdy c=%0d got=%b exp=0", c, if2.in_ready); end
            checks++; if (!if2.out_valid || if2.out_data !== expq[0]) begin failures++; $display("FAIL bp_stable c=%0d got=%h exp=%h", c, if2.out_data, expq[0]); end
         end
         if (if2.in_ready) begin
            e = ref_res(if2.in_data, 1'b0, 1'b0); expq.push_back(e[15:0]); n_acc++;
         end
      end
      checks++; if (n_acc != 3) begin failures++; $display("FAIL bp_accepted got=%0d exp=3", n_acc); end
      @(negedge clk);
      if2.out_ready = 1'b1; if2.in_data = 16'hFF00 + 16'(n_acc);
      #1;
      checks++; if (if2.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_rdy got=%b exp=1", if2.in_ready); end
      checks++; if (!if2.out_valid || if2.out_data !== expq[0]) begin failures++; $display("FAIL bp_release_out got=%h exp=%h", if2.out_data, expq[0]); end
      void'(expq.pop_front());
      if (if2.in_ready) begin
         e = ref_res(if2.in_data, 1'b0, 1'b0); expq.push_back(e[15:0]); n_acc++;
      end
      @(negedge clk);
      if2.out_ready = 1'b0; if2.in_valid = 1'b0;
      #1;
      checks++; if (if2.in_ready !== 1'b0) begin failures++; $display("FAIL bp_refull_rdy got=%b exp=0", if2.in_ready); end
      checks++; if (if2.out_data !== expq[0]) begin failures++; $display("FAIL bp_next got=%h exp=%h", if2.out_data, expq[0]); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if2.out_ready = 1'b1;
         #1;
         if (if2.out_valid) begin
            checks++;
            if (expq.size() == 0) begin
               failures++; $display("FAIL bp_spurious got=%h exp=none", if2.out_data);
            end else if (if2.out_data !== expq[0]) begin
               failures++; $display("FAIL bp_order got=%h exp=%h", if2.out_data, expq[0]);
            end
            if (expq.size() != 0) void'(expq.pop_front());
         end
      end
      checks++; if (expq.size() != 0) begin failures++; $display("FAIL bp_drain got=%0d exp=0", expq.size()); end
   endtask

   task automatic test_sat_counter;
      int n_out;
      logic [3:0] ec;
      n_out = 0;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         if2.out_ready = 1'b1;
         if2.in_valid  = (c < 20);
         if2.in_data   = 16'h8000;
         if2.in_op     = c[0];
         #1;
         if (if2.out_valid) begin
            ec = (n_out > 15) ? 4'hF : n_out[3:0];
            checks++; if (if2.ovf_count !== ec) begin failures++; $display("FAIL sat_cnt n=%0d got=%h exp=%h", n_out, if2.ovf_count, ec); end
            checks++; if ({if2.out_ovf, if2.out_data} !== 17'h18000) begin failures++; $display("FAIL sat_dat n=%0d got=%h exp=18000", n_out, {if2.out_ovf, if2.out_data}); end
            n_out++;
         end
      end
      checks++; if (n_out != 20) begin failures++; $display("FAIL sat_outputs got=%0d exp=20", n_out); end
      checks++; if (if2.ovf_count !== 4'hF) begin failures++; $display("FAIL sat_final got=%h exp=f", if2.ovf_count); end
   endtask

   task automatic test_reset_flight;
      @(negedge clk);
      if0.out_ready = 1'b0; if0.in_valid = 1'b1; if0.in_data = 16'h8000; if0.in_op = 1'b0;
      @(negedge clk);
      if0.in_data = 16'h1234;
      @(negedge clk);
      if0.in_valid = 1'b0;
      #1;
      checks++; if (if0.in_ready !== 1'b0) begin failures++; $display("FAIL rf_full got=%b exp=0", if0.in_ready); end
      @(negedge clk);
      rst = 1'b1; if0.in_valid = 1'b1; if0.in_data = 16'h7777; if0.out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0; if0.in_valid = 1'b0;
      #1;
      checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL rf_vld_d0 got=%b exp=0", if0.out_valid); end
      checks++; if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL rf_vld_d1 got=%b exp=0", if1.out_valid); end
      checks++; if (if0.ovf_count !== 16'h0) begin failures++; $display("FAIL rf_cnt_d0 got=%h exp=0", if0.ovf_count); end
      checks++; if (if1.ovf_count !== 16'h0) begin failures++; $display("FAIL rf_cnt_d1 got=%h exp=0", if1.ovf_count); end
      checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL rf_rdy got=%b exp=1", if0.in_ready); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL rf_stale c=%0d got=%b exp=0", c, if0.out_valid); end
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if0.in_valid = (c == 0); if0.in_data = 16'hFFF0; if0.in_op = 1'b0;
         #1;
         if (c == 2) begin
            checks++; if (!if0.out_valid || {if0.out_ovf, if0.out_data} !== 17'h00010) begin failures++; $display("FAIL rf_next_d0 got=%h exp=00010", {if0.out_ovf, if0.out_data}); end
            checks++; if (!if1.out_valid || {if1.out_ovf, if1.out_data} !== 17'h00010) begin failures++; $display("FAIL rf_next_d1 got=%h exp=00010", {if1.out_ovf, if1.out_data}); end
         end else begin
            checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL rf_next_lat c=%0d got=%b exp=0", c, if0.out_valid); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_sat_counter();
      test_reset_flight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/abs_pipe.md
# abs_pipe

Parametrised, pipelined absolute-value / negate unit: successor to the fixed 16-bit combinational absolute-value block. Accepts two's-complement operands of WIDTH bits over a valid/ready stream. Returns |x| or −x after STAGES cycles, with an overflow flag, optional saturation and a running overflow counter. Sits between the operand fetch and the downstream arithmetic datapath, and replaces direct instantiation of the combinational block wherever throughput under backpressure matters.

## Interface
- WIDTH, 16: operand/result width in bits; legal ≥ 2.
- STAGES, 2: pipeline depth in register stages; legal 1..4.
- SATURATE, 0: 1 = overflowing results clamp to 2^(WIDTH−1)−1; 0 = wrap (result equals the input bit pattern).
- CNT_W, 16: width of the overflow counter.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  unit can accept an operand this cycle.
- in_data  input  WIDTH  signed operand.
- in_op  input  1  0 = absolute value, 1 = negate.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  result.
- out_ovf  output  1  result overflowed, i.e. the operand was −2^(WIDTH−1).
- ovf_count  output  CNT_W  number of overflowing results delivered; saturating.

## Operation
- Arithmetic is performed in stage 1, on the captured operand x with sign s = x[WIDTH−1]:
  - abs: result = (x XOR {WIDTH{s}}) + s. Non-negative operands pass through unchanged.
  - negate: result = (~x) + 1.
  - Both use one WIDTH-bit adder with carry-in; no wider intermediate is kept.
- Overflow occurs only when x = 1 followed by WIDTH−1 zeros, for either op.
  - out_ovf = 1 for that result.
  - SATURATE=0: out_data = x (wrapped).
  - SATURATE=1: out_data = 0 followed by WIDTH−1 ones.
  - Negate of 0 gives 0 with ovf = 0. Abs of a negative non-minimum operand is exact.
- Stages 2..STAGES are plain delay registers for data, ovf and valid.
- Each stage k holds v[k]. Stage k advances when v[k]=0 or stage k+1 advances; the last stage advances when out_valid && out_ready.
- in_ready = stage 1 advances. It is combinational from out_ready through the stage chain. No bubbles persist: an empty stage always accepts from upstream.
- A transfer occurs on in_valid && in_ready and on out_valid && out_ready. Data, op and ovf move together and order is preserved.
- ovf_count increments by 1 on each output transfer with out_ovf=1. It holds at all-ones and never wraps.
- While out_valid=1 and out_ready=0, out_data and out_ovf hold stable.

## Timing
- Latency: an operand accepted at edge n appears with out_valid=1 after edge n+STAGES−1, i.e. usable in the cycle following that edge, when no backpressure is applied.
- Throughput: one result per cycle with out_ready held high.
- Capacity is STAGES entries. With out_ready=0 the unit accepts exactly STAGES operands, then in_ready=0.
- If out_ready rises while full, in_ready rises in the same cycle, so simultaneous input and output transfers are allowed.
- Reset:
  - Clears every v[k], so out_valid=0, out_data=0, out_ovf=0 and ovf_count=0.
  - in_ready=1 in the cycle after reset releases.
  - Reset mid-operation discards all in-flight operands silently and does not count their overflows.
  - Inputs are ignored while rst=1.

## Test plan
- WIDTH=16, STAGES=2, out_ready=1, stream 0x0005, 0xFFFB, 0x0000, 0x7FFF with op=0:
  - outputs 0x0005, 0x0005, 0x0000, 0x7FFF, back-to-back, 2 cycles after each input, all ovf=0.
- Operand 0x8000, op=0 then op=1:
  - SATURATE=0: out_data=0x8000 with ovf=1 both times, ovf_count=2.
  - SATURATE=1: out_data=0x7FFF with ovf=1 both times, ovf_count=2.
- Negate 0x0001 → 0xFFFF; 0xFFFF → 0x0001; 0x0000 → 0x0000; all ovf=0.
- Backpressure with STAGES=3, out_ready=0, continuous in_valid:
  - exactly 3 accepted, then in_ready=0 and out_data stable.
  - Raise out_ready for 1 cycle: one output and one input transfer occur in that same cycle, and order is preserved.
- CNT_W=4 with 20 overflowing operands: ovf_count stops at 0xF.
- Assert rst for 1 cycle with 2 results in flight, including one 0x8000:
  - out_valid=0 and ovf_count=0 next cycle, no stale outputs afterwards.
  - The next operand 0xFFF0 yields 0x0010.
